// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: store-strobe and status bundle between the core's
// PortOut/PortIn side and the serial transmit port.
//   WriteEnable : one-cycle store strobe from the core
//   WriteData   : store data, only [7:0] is transmitted
//   Busy        : a frame is on the line
//   Full/Empty  : transmit FIFO occupancy flags
//   Overflow    : sticky, a store was dropped because the FIFO was full
interface uart_tx_port_if;
    logic        WriteEnable;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Full;
    logic        Empty;
    logic        Overflow;

    modport master (output WriteEnable, WriteData,
                    input  Busy, Full, Empty, Overflow);
    modport slave  (input  WriteEnable, WriteData,
                    output Busy, Full, Empty, Overflow);
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: byte FIFO plus 8N1 serialiser on a single Tx line.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : store strobe/data in, Busy/Full/Empty/Overflow out
//   Tx    : registered serial output, idle high
module uart_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_port_if.slave  bus,
    output logic           Tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, overflow;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_end, tx_nxt, busy;

    // upper store bits are intentionally ignored
    logic unused_hi;
    assign unused_hi = ^bus.WriteData[31:8];

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // full is the pre-edge value, so a same-cycle pop does not rescue the write
    assign push     = bus.WriteEnable && !full;
    assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.WriteData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (bus.WriteEnable && full) overflow <= 1'b1;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            Tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            Tx    <= tx_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!empty) state_nxt = START;
            START: if (baud_end) state_nxt = DATA;
            DATA:  if (baud_end && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (baud_end) state_nxt = empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Tx is registered, so its next value is the level of the state being
    // entered; inside DATA a bit boundary exposes the bit about to shift down.
    always_comb begin
        busy   = (state != IDLE);
        pop    = !empty && ((state == IDLE) || (state == STOP && baud_end));
        tx_nxt = 1'b1;
        case (state_nxt)
            START: tx_nxt = 1'b0;
            DATA:  tx_nxt = (state == DATA && baud_end) ? shift[1] : shift[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // ---------------- shift / baud datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state != IDLE) begin
            baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
            if (state == DATA && baud_end) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign bus.Busy     = busy;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
    assign bus.Overflow = overflow;
endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FR    = 10 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic Tx;
    int   checks = 0;
    int   failures = 0;

    uart_tx_port_if bus();

    uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .Tx(Tx)
    );

    always #5 clk = ~clk;

    // ---------- reference model: byte queue + frame countdown ----------
    logic [7:0] mq[$];
    logic [7:0] acc_q[$];
    logic [7:0] m_byte = 8'h00;
    int         m_rem = 0;
    logic       m_ovf = 1'b0;

    always @(posedge clk or negedge reset) begin
        int  pre_sz;
        bit  do_pop;
        if (!reset) begin
            mq.delete(); acc_q.delete();
            m_rem = 0; m_ovf = 1'b0;
        end else begin
            pre_sz = mq.size();
            do_pop = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && pre_sz > 0) do_pop = 1;
            end else if (pre_sz > 0) do_pop = 1;
            if (do_pop) begin
                m_byte = mq.pop_front();
                m_rem  = FR;
            end
            if (bus.WriteEnable) begin
                if (pre_sz == DEPTH) m_ovf = 1'b1;
                else begin
                    mq.push_back(bus.WriteData[7:0]);
                    acc_q.push_back(bus.WriteData[7:0]);
                end
            end
        end
    end

    function automatic logic exp_tx();
        int b;
        if (m_rem == 0) return 1'b1;
        b = (FR - m_rem) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    // ---------- line decoder: mid-bit sampling of Tx ----------
    logic [7:0] rx_q[$];
    bit         in_fr = 0;
    int         dc = 0;
    logic [7:0] dsh = 8'h00;

    always @(negedge clk) begin
        if (!reset) in_fr = 0;
        else if (!in_fr) begin
            if (Tx === 1'b0) begin in_fr = 1; dc = 0; end
        end else begin
            dc++;
            if (dc % CPB == CPB/2 && dc/CPB >= 1 && dc/CPB <= 8) dsh[dc/CPB-1] = Tx;
            if (dc == FR-1) begin rx_q.push_back(dsh); in_fr = 0; end
        end
    end

    // drive one cycle of inputs starting at a negedge, return at next negedge
    task automatic cyc(input logic we, input logic [7:0] d);
        bus.WriteEnable = we;
        bus.WriteData   = $urandom();
        bus.WriteData[7:0] = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(0, 8'h00); cyc(0, 8'h00);
        reset = 1'b1;
        cyc(0, 8'h00);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cyc(0, 8'h00);
        reset = 1'b1;
        cyc(0, 8'h00);
        checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", Tx); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.Empty); end
        checks++; if (bus.Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.Full); end
        checks++; if (bus.Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.Overflow); end
        for (int i = 0; i < 50; i++) begin
            cyc(0, 8'h00);
            checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL idle_tx cyc=%0d got=%b exp=1", i, Tx); end
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic       lvl;
        int         b;
        d = 8'h55;
        rx_q.delete();
        cyc(1, d);
        checks++; if (Tx !== 1'b1 || bus.Empty !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++; $display("FAIL single_e0 tx=%b empty=%b busy=%b exp 1,0,0", Tx, bus.Empty, bus.Busy); end
        cyc(0, 8'h00);
        checks++; if (Tx !== 1'b0 || bus.Busy !== 1'b1 || bus.Empty !== 1'b1) begin
            failures++; $display("FAIL single_e1 tx=%b busy=%b empty=%b exp 0,1,1", Tx, bus.Busy, bus.Empty); end
        for (int i = 0; i < FR; i++) begin
            b = i / CPB;
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            checks++; if (Tx !== lvl || bus.Busy !== 1'b1) begin
                failures++; $display("FAIL single_level cyc=%0d tx=%b exp=%b busy=%b", i, Tx, lvl, bus.Busy); end
            cyc(0, 8'h00);
        end
        checks++; if (bus.Busy !== 1'b0 || Tx !== 1'b1) begin
            failures++; $display("FAIL single_end busy=%b tx=%b exp 0,1", bus.Busy, Tx); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            failures++; $display("FAIL single_byte n=%0d got=%h exp=55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    endtask

    task automatic test_back_to_back();
        int run, guard;
        rx_q.delete();
        cyc(1, 8'hA5);
        cyc(1, 8'h3C);
        run = 0; guard = 0;
        while (bus.Busy === 1'b1 && guard < 300) begin
            checks++; if (Tx !== exp_tx()) begin
                failures++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", run, Tx, exp_tx()); end
            run++; guard++;
            cyc(0, 8'h00);
        end
        checks++; if (run != 2*FR) begin failures++; $display("FAIL b2b_busy_run got=%0d exp=%0d", run, 2*FR); end
        checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
            failures++; $display("FAIL b2b_bytes n=%0d exp A5,3C", rx_q.size()); end
    endtask

    task automatic test_overflow();
        int guard;
        rx_q.delete();
        for (int k = 1; k <= 6; k++) begin
            cyc(1, 8'(k));
            if (k == 5) begin
                checks++; if (bus.Full !== 1'b1 || bus.Overflow !== 1'b0) begin
                    failures++; $display("FAIL ovf_after5 full=%b ovf=%b exp 1,0", bus.Full, bus.Overflow); end
            end
        end
        checks++; if (bus.Overflow !== 1'b1 || bus.Full !== 1'b1) begin
            failures++; $display("FAIL ovf_after6 ovf=%b full=%b exp 1,1", bus.Overflow, bus.Full); end
        guard = 0;
        while ((bus.Busy !== 1'b0 || bus.Empty !== 1'b1) && guard < 400) begin cyc(0, 8'h00); guard++; end
        checks++; if (guard >= 400) begin failures++; $display("FAIL ovf_drain_timeout got=%0d exp<400", guard); end
        checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL ovf_count got=%0d exp=5", rx_q.size()); end
        for (int k = 0; k < rx_q.size() && k < 5; k++) begin
            checks++; if (rx_q[k] !== 8'(k+1)) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", k, rx_q[k], 8'(k+1)); end
        end
        checks++; if (bus.Overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.Overflow); end
    endtask

    task automatic test_simul_push_pop();
        int waited, guard;
        logic [7:0] exp_b [6];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        rx_q.delete();
        cyc(1, 8'h11); cyc(1, 8'h22); cyc(1, 8'h33);
        waited = 0;
        while (m_rem != 1 && waited < 100) begin cyc(0, 8'h00); waited++; end
        checks++; if (waited != 38) begin failures++; $display("FAIL simul_wait got=%0d exp=38", waited); end
        cyc(1, 8'h44);  // lands on the end-of-stop pop edge
        checks++; if (Tx !== 1'b0 || bus.Empty !== 1'b0 || bus.Full !== 1'b0) begin
            failures++; $display("FAIL simul_edge tx=%b empty=%b full=%b exp 0,0,0", Tx, bus.Empty, bus.Full); end
        cyc(1, 8'h55); cyc(1, 8'h66);
        checks++; if (bus.Full !== 1'b1 || bus.Overflow !== 1'b0) begin
            failures++; $display("FAIL simul_count full=%b ovf=%b exp 1,0", bus.Full, bus.Overflow); end
        guard = 0;
        while ((bus.Busy !== 1'b0 || bus.Empty !== 1'b1) && guard < 400) begin cyc(0, 8'h00); guard++; end
        checks++; if (rx_q.size() != 6) begin failures++; $display("FAIL simul_n got=%0d exp=6", rx_q.size()); end
        for (int k = 0; k < rx_q.size() && k < 6; k++) begin
            checks++; if (rx_q[k] !== exp_b[k]) begin failures++; $display("FAIL simul_byte%0d got=%h exp=%h", k, rx_q[k], exp_b[k]); end
        end
    endtask

    task automatic test_reset_midframe();
        rx_q.delete();
        cyc(1, 8'hFF); cyc(1, 8'hA1); cyc(1, 8'hB2);
        repeat (16) cyc(0, 8'h00);   // now inside data bit 3
        checks++; if (bus.Busy !== 1'b1 || Tx !== 1'b1) begin
            failures++; $display("FAIL mid_pre busy=%b tx=%b exp 1,1", bus.Busy, Tx); end
        #2 reset = 1'b0;
        #1;
        checks++; if (Tx !== 1'b1 || bus.Empty !== 1'b1 || bus.Busy !== 1'b0 || bus.Full !== 1'b0) begin
            failures++; $display("FAIL mid_reset tx=%b empty=%b busy=%b full=%b exp 1,1,0,0", Tx, bus.Empty, bus.Busy, bus.Full); end
        @(negedge clk);
        cyc(0, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(0, 8'h00);
            checks++; if (Tx !== 1'b1 || bus.Busy !== 1'b0) begin
                failures++; $display("FAIL mid_after cyc=%0d tx=%b busy=%b exp 1,0", i, Tx, bus.Busy); end
        end
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL mid_frames got=%0d exp=0", rx_q.size()); end
    endtask

    task automatic test_random();
        int pct, guard;
        logic et;
        do_reset();
        rx_q.delete();
        for (int i = 0; i < 1500; i++) begin
            pct = (i / 250) % 3 == 0 ? 3 : (i / 250) % 3 == 1 ? 50 : 12;
            cyc($urandom_range(0, 99) < pct, 8'($urandom()));
            et = exp_tx();
            checks++; if (Tx !== et || bus.Busy !== (m_rem > 0) || bus.Full !== (mq.size() == DEPTH) ||
                          bus.Empty !== (mq.size() == 0) || bus.Overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand cyc=%0d tx=%b/%b busy=%b/%b full=%b/%b empty=%b/%b ovf=%b/%b", i,
                         Tx, et, bus.Busy, m_rem > 0, bus.Full, mq.size() == DEPTH,
                         bus.Empty, mq.size() == 0, bus.Overflow, m_ovf);
            end
        end
        guard = 0;
        while ((bus.Busy !== 1'b0 || bus.Empty !== 1'b1) && guard < 600) begin cyc(0, 8'h00); guard++; end
        cyc(0, 8'h00);
        checks++; if (rx_q.size() != acc_q.size()) begin
            failures++; $display("FAIL rand_n got=%0d exp=%0d", rx_q.size(), acc_q.size()); end
        for (int k = 0; k < rx_q.size() && k < acc_q.size(); k++) begin
            checks++; if (rx_q[k] !== acc_q[k]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", k, rx_q[k], acc_q[k]); end
        end
    endtask

    initial begin
        bus.WriteEnable = 1'b0;
        bus.WriteData   = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul_push_pop();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped serial output stage downstream of the MIPS processor's `PortOut` bus. It accepts byte writes from the core into a small FIFO and serialises them as 8N1 UART frames on a single `Tx` line. Status flags feed back to the core's input port so software can poll before storing. The block owns no processor state; it only consumes store strobes and data.

## Interface

- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥2.
- `FIFO_DEPTH`, 4: byte entries in the transmit FIFO; power of two, ≥2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `WriteEnable` input 1: one-cycle store strobe from the core.
- `WriteData` input 32: store data; only bits [7:0] are used.
- `Tx` output 1: serial line, idle high.
- `Busy` output 1: high while a frame is on the line (START, DATA, STOP).
- `Full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `Empty` output 1: FIFO holds 0 entries.
- `Overflow` output 1: sticky; set when a write is dropped because the FIFO is full.

## Operation

- FIFO: circular buffer with `log2(FIFO_DEPTH)`-bit read/write pointers that wrap modulo depth, plus a `log2(FIFO_DEPTH)+1`-bit count register.
- Push: on an edge with `WriteEnable`=1 and `Full`=0 (registered value, pre-edge), store `WriteData[7:0]` at the write pointer, advance the pointer, and increment the count.
- Write while `Full`=1: data discarded, `Overflow` set. This applies even if a pop happens in the same cycle. `Overflow` is cleared only by reset.
- Pop: performed by the FSM when it loads the shift register; advances the read pointer and decrements the count.
- Simultaneous push and pop (not full): both take effect; the count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `Tx`=1. If `Empty`=0, pop into the 8-bit shift register, clear the baud counter and bit index, and go to START.
  - START: `Tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `Tx`=shift[0], LSB first. After each `CLKS_PER_BIT` cycles, shift right and increment the 3-bit bit index. After bit 7, go to STOP.
  - STOP: `Tx`=1 for `CLKS_PER_BIT` cycles. At the end of STOP:
    - FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
    - FIFO empty: go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- `Tx` is driven from a register, so it is glitch-free.
- `Busy` = (state ≠ IDLE). `Full` and `Empty` are derived from the count register.

## Timing

- Reset values, applied asynchronously on `reset`=0:
  - outputs: `Tx`=1, `Busy`=0, `Full`=0, `Empty`=1, `Overflow`=0;
  - internal: pointers and count 0, state IDLE.
- Reset mid-frame: `Tx` returns high immediately, FIFO contents are lost, and no partial frame resumes after release.
- Write accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - `Empty`=0 after E0;
  - at edge E1 the FSM pops, `Tx`=0, `Busy`=1 and `Empty`=1.
  - Write-to-start-bit latency is therefore 2 edges.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles of `Busy`=1 per byte (start + 8 data + stop).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `Full`/`Empty`/`Overflow` update on the edge that changes the count or drops the write; they are visible the same cycle the core next samples.
- Throughput: one byte per 10×`CLKS_PER_BIT` cycles. The core may issue at most `FIFO_DEPTH` writes in a burst plus one more per frame completed.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.

- Reset: hold `reset`=0 for 3 cycles, then release → `Tx`=1, `Busy`=0, `Empty`=1, `Full`=0, `Overflow`=0; `Tx` stays 1 for 50 idle cycles.
- Single byte: write 0x55 → `Tx` goes low 2 edges after the write. Each level lasts 4 cycles, in this order:
  - start 0;
  - data 1,0,1,0,1,0,1,0;
  - stop 1.
  - `Busy` is high for exactly 40 cycles, then IDLE.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles → two frames separated by zero idle cycles.
  - 0xA5 data bits: 1,0,1,0,0,1,0,1.
  - 0x3C data bits: 0,0,1,1,1,1,0,0.
  - `Busy` is high for 80 consecutive cycles.
- Full/overflow: write 6 bytes (0x01–0x06) on consecutive cycles starting from idle.
  - The first byte is popped after 2 edges, so 0x01–0x05 are accepted.
  - `Full`=1 after the 5th write; the 6th write is dropped and `Overflow`=1.
  - Serial output is exactly 0x01,0x02,0x03,0x04,0x05.
- Simultaneous push/pop: with FIFO holding 2 entries, write on the cycle of the end-of-STOP pop → count stays 2 and bytes are emitted in write order.
- Reset mid-frame: assert `reset` during data bit 3 of 0xFF with 2 bytes queued → `Tx`=1 immediately, `Empty`=1. After release, no further frames appear without new writes.
